// File: rtl/mem_resp_stage.sv
// mem_resp_stage
// ----------------------------------------------------------------------------
// MEM pipeline stage of the LoongArch core, between EX and WB. The data memory
// uses a split request/response protocol: EX issues the request (addr_ok) and
// this stage waits for the matching data_ok. It then aligns and extends the
// load data. A returned word is held in a one-entry buffer while WB stalls.
// Responses that belong to flushed instructions are counted and dropped.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   es_to_ms_valid      EX offers an instruction
//   ms_allowin          MS accepts an instruction this cycle
//   es_pc/alu_result/dest/gr_we/mem_op/req_issued/side
//                       EX payload (alu_result[1:0] is the byte offset)
//   es_cancel_inc       EX dropped an issued request; one orphan response is owed
//   data_ok, rdata      memory response
//   flush               exception/ertn flush
//   ws_allowin          WB accepts
//   ms_to_ws_valid      MS output valid
//   ms_pc/result/dest/gr_we/side
//                       payload to WB
//   fwd_valid/blocked/dest/result
//                       forwarding/interlock info for ID
//   discard_cnt         orphaned responses still to be dropped
// ----------------------------------------------------------------------------
module mem_resp_stage #(
  parameter int SIDE_W          = 96,
  parameter int MAX_OUTSTANDING = 2,
  parameter int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              es_to_ms_valid,
  output logic              ms_allowin,
  input  logic [31:0]       es_pc,
  input  logic [31:0]       es_alu_result,
  input  logic [4:0]        es_dest,
  input  logic              es_gr_we,
  input  logic [2:0]        es_mem_op,
  input  logic              es_req_issued,
  input  logic [SIDE_W-1:0] es_side,
  input  logic              es_cancel_inc,
  input  logic              data_ok,
  input  logic [31:0]       rdata,
  input  logic              flush,
  input  logic              ws_allowin,
  output logic              ms_to_ws_valid,
  output logic [31:0]       ms_pc,
  output logic [31:0]       ms_result,
  output logic [4:0]        ms_dest,
  output logic              ms_gr_we,
  output logic [SIDE_W-1:0] ms_side,
  output logic              fwd_valid,
  output logic              fwd_blocked,
  output logic [4:0]        fwd_dest,
  output logic [31:0]       fwd_result,
  output logic [CNT_W-1:0]  discard_cnt
);

  localparam logic [2:0] OP_NONE = 3'd0;
  localparam logic [2:0] OP_LDW  = 3'd1;
  localparam logic [2:0] OP_LDB  = 3'd2;
  localparam logic [2:0] OP_LDBU = 3'd3;
  localparam logic [2:0] OP_LDH  = 3'd4;
  localparam logic [2:0] OP_LDHU = 3'd5;

  logic              ms_valid;
  logic [31:0]       pc_r;
  logic [31:0]       alu_result_r;
  logic [4:0]        dest_r;
  logic              gr_we_r;
  logic [2:0]        mem_op_r;
  logic              req_issued_r;
  logic [SIDE_W-1:0] side_r;

  logic [31:0]       resp_buf;
  logic              resp_buf_valid;
  logic [CNT_W-1:0]  discard_cnt_r;

  logic              need_resp;
  logic              direct_hit;
  logic              ready_go;
  logic              leave;
  logic              is_load;
  logic              ms_orphan;
  logic              cnt_dec;
  logic [31:0]       load_word;
  logic [7:0]        load_byte;
  logic [15:0]       load_half;
  logic [31:0]       result;

  // A response can only be taken directly when no orphan is still pending
  // ahead of it: the counter always consumes the oldest responses first.
  assign need_resp      = ms_valid && req_issued_r;
  assign direct_hit     = data_ok && (discard_cnt_r == '0) && need_resp && !resp_buf_valid;
  assign ready_go       = !need_resp || resp_buf_valid || direct_hit;
  assign ms_allowin     = !ms_valid || (ready_go && ws_allowin);
  assign ms_to_ws_valid = ms_valid && ready_go && !flush;
  assign leave          = ms_to_ws_valid && ws_allowin;

  assign is_load   = (mem_op_r >= OP_LDW) && (mem_op_r <= OP_LDHU);
  assign ms_orphan = flush && need_resp && !resp_buf_valid && !direct_hit;
  assign cnt_dec   = data_ok && (discard_cnt_r != '0);

  // Pipeline register. Flush wins over capture, so an instruction arriving
  // from EX in a flush cycle is dropped. Payload only changes on capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      ms_valid     <= 1'b0;
      pc_r         <= '0;
      alu_result_r <= '0;
      dest_r       <= '0;
      gr_we_r      <= 1'b0;
      mem_op_r     <= OP_NONE;
      req_issued_r <= 1'b0;
      side_r       <= '0;
    end else if (flush) begin
      ms_valid <= 1'b0;
    end else if (ms_allowin) begin
      ms_valid <= es_to_ms_valid;
      if (es_to_ms_valid) begin
        pc_r         <= es_pc;
        alu_result_r <= es_alu_result;
        dest_r       <= es_dest;
        gr_we_r      <= es_gr_we;
        mem_op_r     <= es_mem_op;
        req_issued_r <= es_req_issued;
        side_r       <= es_side;
      end
    end
  end

  // Response buffer: holds the word returned while WB is stalled, so the
  // result stays stable even after rdata moves on. Emptied when the
  // instruction leaves or is flushed.
  always_ff @(posedge clk) begin
    if (reset) begin
      resp_buf       <= '0;
      resp_buf_valid <= 1'b0;
    end else if (flush || leave) begin
      resp_buf_valid <= 1'b0;
    end else if (direct_hit && !ws_allowin) begin
      resp_buf       <= rdata;
      resp_buf_valid <= 1'b1;
    end
  end

  // Orphan counter: flushed waiters and EX cancellations add, every response
  // seen while the counter is non-zero is swallowed. All three may happen in
  // the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      discard_cnt_r <= '0;
    end else begin
      discard_cnt_r <= discard_cnt_r + CNT_W'(ms_orphan) + CNT_W'(es_cancel_inc)
                       - CNT_W'(cnt_dec);
    end
  end

  // Load alignment and extension. Halfword selection ignores offset bit 0;
  // misaligned accesses are trapped in EX.
  always_comb begin
    load_word = resp_buf_valid ? resp_buf : rdata;
    load_byte = load_word[7:0];
    case (alu_result_r[1:0])
      2'd0:    load_byte = load_word[7:0];
      2'd1:    load_byte = load_word[15:8];
      2'd2:    load_byte = load_word[23:16];
      default: load_byte = load_word[31:24];
    endcase
    load_half = alu_result_r[1] ? load_word[31:16] : load_word[15:0];
    case (mem_op_r)
      OP_LDW:  result = load_word;
      OP_LDB:  result = {{24{load_byte[7]}}, load_byte};
      OP_LDBU: result = {24'd0, load_byte};
      OP_LDH:  result = {{16{load_half[15]}}, load_half};
      OP_LDHU: result = {16'd0, load_half};
      default: result = alu_result_r;
    endcase
  end

  assign ms_pc       = pc_r;
  assign ms_result   = result;
  assign ms_dest     = dest_r;
  assign ms_gr_we    = gr_we_r;
  assign ms_side     = side_r;
  assign fwd_valid   = ms_valid && gr_we_r;
  assign fwd_blocked = fwd_valid && is_load && !ready_go;
  assign fwd_dest    = dest_r;
  assign fwd_result  = result;
  assign discard_cnt = discard_cnt_r;

endmodule

// File: tb/tb_mem_resp_stage.sv
// tb_mem_resp_stage
// ----------------------------------------------------------------------------
// Directed bench for mem_resp_stage: inputs change 1 time unit after each
// rising edge, outputs are sampled a further time unit later. A negedge
// monitor watches for illegal memory responses and counter overflow.
// ----------------------------------------------------------------------------
module tb_mem_resp_stage;

  localparam int SIDE_W = 96;
  localparam int MAX_OUTSTANDING = 2;
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  logic              clk;
  logic              reset;
  logic              es_to_ms_valid;
  logic              ms_allowin;
  logic [31:0]       es_pc;
  logic [31:0]       es_alu_result;
  logic [4:0]        es_dest;
  logic              es_gr_we;
  logic [2:0]        es_mem_op;
  logic              es_req_issued;
  logic [SIDE_W-1:0] es_side;
  logic              es_cancel_inc;
  logic              data_ok;
  logic [31:0]       rdata;
  logic              flush;
  logic              ws_allowin;
  logic              ms_to_ws_valid;
  logic [31:0]       ms_pc;
  logic [31:0]       ms_result;
  logic [4:0]        ms_dest;
  logic              ms_gr_we;
  logic [SIDE_W-1:0] ms_side;
  logic              fwd_valid;
  logic              fwd_blocked;
  logic [4:0]        fwd_dest;
  logic [31:0]       fwd_result;
  logic [CNT_W-1:0]  discard_cnt;

  int tests = 0;
  int fails = 0;

  mem_resp_stage #(
    .SIDE_W(SIDE_W),
    .MAX_OUTSTANDING(MAX_OUTSTANDING)
  ) dut (
    .clk(clk),
    .reset(reset),
    .es_to_ms_valid(es_to_ms_valid),
    .ms_allowin(ms_allowin),
    .es_pc(es_pc),
    .es_alu_result(es_alu_result),
    .es_dest(es_dest),
    .es_gr_we(es_gr_we),
    .es_mem_op(es_mem_op),
    .es_req_issued(es_req_issued),
    .es_side(es_side),
    .es_cancel_inc(es_cancel_inc),
    .data_ok(data_ok),
    .rdata(rdata),
    .flush(flush),
    .ws_allowin(ws_allowin),
    .ms_to_ws_valid(ms_to_ws_valid),
    .ms_pc(ms_pc),
    .ms_result(ms_result),
    .ms_dest(ms_dest),
    .ms_gr_we(ms_gr_we),
    .ms_side(ms_side),
    .fwd_valid(fwd_valid),
    .fwd_blocked(fwd_blocked),
    .fwd_dest(fwd_dest),
    .fwd_result(fwd_result),
    .discard_cnt(discard_cnt)
  );

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Protocol monitor: a response with nothing to consume it, or more orphans
  // than the memory system can have outstanding, is an error.
  always @(negedge clk) begin
    if (!reset) begin
      tests++;
      assert (!(data_ok && (discard_cnt == '0) && !(dut.need_resp && !dut.resp_buf_valid)))
      else begin
        fails++;
        $error("[TB] FAIL stray_data_ok: observed 1 expected 0 at %0t", $time);
      end
      tests++;
      assert (int'(discard_cnt) <= MAX_OUTSTANDING)
      else begin
        fails++;
        $error("[TB] FAIL cnt_overflow: observed %0d expected <= %0d", discard_cnt, MAX_OUTSTANDING);
      end
    end
  end

  // Advance one clock edge and give the registers time to update.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  // Settle combinational outputs, then compare one observed value.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    #0;
    tests++;
    assert (observed === expected)
    else begin
      fails++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Present one instruction from EX for a single cycle.
  task automatic issueInsn(input logic [2:0] op, input logic [31:0] alu,
                           input logic [4:0] dest, input logic we, input logic issued);
    es_to_ms_valid = 1'b1;
    es_mem_op      = op;
    es_alu_result  = alu;
    es_dest        = dest;
    es_gr_we       = we;
    es_req_issued  = issued;
    es_pc          = 32'h1c00_0000 + alu;
    applyStimulus();
    es_to_ms_valid = 1'b0;
    es_req_issued  = 1'b0;
  endtask

  // Load that gets its response in the cycle right after capture.
  task automatic runLoad(input string tag, input logic [2:0] op, input logic [31:0] alu,
                         input logic [31:0] rd, input logic [31:0] expected);
    issueInsn(op, alu, 5'd3, 1'b1, 1'b1);
    data_ok = 1'b1;
    rdata   = rd;
    #1;
    checkOutput(tag, ms_result, expected);
    applyStimulus();
    data_ok = 1'b0;
  endtask

  initial begin
    reset          = 1'b1;
    es_to_ms_valid = 1'b0;
    es_pc          = '0;
    es_alu_result  = '0;
    es_dest        = '0;
    es_gr_we       = 1'b0;
    es_mem_op      = '0;
    es_req_issued  = 1'b0;
    es_side        = '0;
    es_cancel_inc  = 1'b0;
    data_ok        = 1'b0;
    rdata          = '0;
    flush          = 1'b0;
    ws_allowin     = 1'b1;

    applyStimulus();
    applyStimulus();
    reset = 1'b0;
    #1;
    checkOutput("rst_valid", 32'(ms_to_ws_valid), 32'd0);
    checkOutput("rst_allowin", 32'(ms_allowin), 32'd1);
    checkOutput("rst_fwd_valid", 32'(fwd_valid), 32'd0);
    checkOutput("rst_fwd_blocked", 32'(fwd_blocked), 32'd0);
    checkOutput("rst_fwd_dest", 32'(fwd_dest), 32'd0);
    checkOutput("rst_fwd_result", fwd_result, 32'd0);
    checkOutput("rst_cnt", 32'(discard_cnt), 32'd0);

    // Basic ld.w with forwarding interlock before the response.
    es_side = {32'hCAFE_0001, 32'h0BAD_F00D, 32'h1234_ABCD};
    issueInsn(3'd1, 32'h0000_1000, 5'd5, 1'b1, 1'b1);
    #1;
    checkOutput("ldw_wait_valid", 32'(ms_to_ws_valid), 32'd0);
    checkOutput("ldw_wait_allowin", 32'(ms_allowin), 32'd0);
    checkOutput("ldw_fwd_blocked", 32'(fwd_blocked), 32'd1);
    data_ok = 1'b1;
    rdata   = 32'h1234_5678;
    #1;
    checkOutput("ldw_valid", 32'(ms_to_ws_valid), 32'd1);
    checkOutput("ldw_result", ms_result, 32'h1234_5678);
    checkOutput("ldw_pc", ms_pc, 32'h1c00_1000);
    checkOutput("ldw_side_hi", ms_side[95:64], 32'hCAFE_0001);
    checkOutput("ldw_fwd_unblocked", 32'(fwd_blocked), 32'd0);
    checkOutput("ldw_fwd_result", fwd_result, 32'h1234_5678);
    checkOutput("ldw_fwd_dest", 32'(fwd_dest), 32'd5);
    applyStimulus();
    data_ok = 1'b0;
    #1;
    checkOutput("ldw_gone", 32'(ms_to_ws_valid), 32'd0);

    // Byte and halfword alignment/extension.
    runLoad("ldb_a3", 3'd2, 32'h0000_1003, 32'h80FF_0000, 32'hFFFF_FF80);
    runLoad("ldbu_a3", 3'd3, 32'h0000_1003, 32'h80FF_0000, 32'h0000_0080);
    runLoad("ldb_a2", 3'd2, 32'h0000_1002, 32'h80FF_0000, 32'hFFFF_FFFF);
    runLoad("ldb_a1", 3'd2, 32'h0000_1001, 32'h80FF_0000, 32'h0000_0000);
    runLoad("ldh_a2", 3'd4, 32'h0000_1002, 32'h8001_0000, 32'hFFFF_8001);
    runLoad("ldhu_a2", 3'd5, 32'h0000_1002, 32'h8001_0000, 32'h0000_8001);
    runLoad("ldh_a0", 3'd4, 32'h0000_1000, 32'h8001_7F02, 32'h0000_7F02);

    // WB stall: data is buffered and held while rdata changes.
    issueInsn(3'd1, 32'h0000_2000, 5'd6, 1'b1, 1'b1);
    ws_allowin = 1'b0;
    data_ok    = 1'b1;
    rdata      = 32'h1234_5678;
    #1;
    checkOutput("stall_valid", 32'(ms_to_ws_valid), 32'd1);
    checkOutput("stall_result0", ms_result, 32'h1234_5678);
    applyStimulus();
    data_ok = 1'b0;
    rdata   = 32'hDEAD_BEEF;
    #1;
    checkOutput("stall_buf_valid", 32'(dut.resp_buf_valid), 32'd1);
    checkOutput("stall_result1", ms_result, 32'h1234_5678);
    checkOutput("stall_allowin", 32'(ms_allowin), 32'd0);
    checkOutput("stall_fwd_blocked", 32'(fwd_blocked), 32'd0);
    applyStimulus();
    #1;
    checkOutput("stall_result2", fwd_result, 32'h1234_5678);
    applyStimulus();
    ws_allowin = 1'b1;
    #1;
    checkOutput("stall_release_valid", 32'(ms_to_ws_valid), 32'd1);
    checkOutput("stall_release_result", ms_result, 32'h1234_5678);
    applyStimulus();
    #1;
    checkOutput("stall_buf_cleared", 32'(dut.resp_buf_valid), 32'd0);
    checkOutput("stall_gone", 32'(ms_to_ws_valid), 32'd0);

    // Flush while a load waits: its response must be dropped.
    issueInsn(3'd1, 32'h0000_3000, 5'd7, 1'b1, 1'b1);
    flush = 1'b1;
    #1;
    checkOutput("flush_valid", 32'(ms_to_ws_valid), 32'd0);
    applyStimulus();
    flush = 1'b0;
    #1;
    checkOutput("flush_cnt1", 32'(discard_cnt), 32'd1);
    issueInsn(3'd1, 32'h0000_3004, 5'd8, 1'b1, 1'b1);
    data_ok = 1'b1;
    rdata   = 32'hAAAA_AAAA;
    #1;
    checkOutput("orphan_not_taken", 32'(ms_to_ws_valid), 32'd0);
    checkOutput("orphan_fwd_blocked", 32'(fwd_blocked), 32'd1);
    applyStimulus();
    rdata = 32'h5555_5555;
    #1;
    checkOutput("orphan_cnt0", 32'(discard_cnt), 32'd0);
    checkOutput("second_valid", 32'(ms_to_ws_valid), 32'd1);
    checkOutput("second_result", ms_result, 32'h5555_5555);
    applyStimulus();
    data_ok = 1'b0;

    // Flush plus EX cancel in one cycle; an EX instruction offered during
    // the flush must not be captured.
    issueInsn(3'd1, 32'h0000_4000, 5'd9, 1'b1, 1'b1);
    flush          = 1'b1;
    es_cancel_inc  = 1'b1;
    es_to_ms_valid = 1'b1;
    es_mem_op      = 3'd0;
    es_alu_result  = 32'h0000_0042;
    applyStimulus();
    flush          = 1'b0;
    es_cancel_inc  = 1'b0;
    es_to_ms_valid = 1'b0;
    #1;
    checkOutput("dual_cnt2", 32'(discard_cnt), 32'd2);
    checkOutput("flush_drops_capture", 32'(ms_to_ws_valid), 32'd0);
    data_ok       = 1'b1;
    es_cancel_inc = 1'b1;
    applyStimulus();
    es_cancel_inc = 1'b0;
    #1;
    checkOutput("inc_dec_cnt2", 32'(discard_cnt), 32'd2);
    applyStimulus();
    #1;
    checkOutput("drain_cnt1", 32'(discard_cnt), 32'd1);
    applyStimulus();
    data_ok = 1'b0;
    #1;
    checkOutput("drain_cnt0", 32'(discard_cnt), 32'd0);

    // Non-memory op forwards immediately.
    issueInsn(3'd0, 32'h0000_0007, 5'd9, 1'b1, 1'b0);
    #1;
    checkOutput("add_valid", 32'(ms_to_ws_valid), 32'd1);
    checkOutput("add_fwd_valid", 32'(fwd_valid), 32'd1);
    checkOutput("add_fwd_blocked", 32'(fwd_blocked), 32'd0);
    checkOutput("add_fwd_result", fwd_result, 32'h0000_0007);
    checkOutput("add_fwd_dest", 32'(fwd_dest), 32'd9);
    applyStimulus();

    // Issued store waits for its response but never blocks forwarding.
    issueInsn(3'd6, 32'h0000_5000, 5'd0, 1'b0, 1'b1);
    #1;
    checkOutput("st_wait_valid", 32'(ms_to_ws_valid), 32'd0);
    checkOutput("st_fwd_valid", 32'(fwd_valid), 32'd0);
    checkOutput("st_fwd_blocked", 32'(fwd_blocked), 32'd0);
    data_ok = 1'b1;
    rdata   = 32'hFFFF_FFFF;
    #1;
    checkOutput("st_valid", 32'(ms_to_ws_valid), 32'd1);
    checkOutput("st_result", ms_result, 32'h0000_5000);
    applyStimulus();
    data_ok = 1'b0;
    applyStimulus();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
